// File: rtl/chip8_pkg.sv
// chip8_pkg: shared types and constants for the CHIP-8 timer block.
//   timer_sel_e  : selects DT or ST on a CPU timer write
//   wait_state_e : wait-for-tick FSM states
//   timer_wr_t   : CPU timer write payload (select + value)
//   TIMER_W      : architectural timer width
package chip8_pkg;

  localparam int unsigned TIMER_W = 8;

  typedef enum logic {
    TMR_DT = 1'b0,
    TMR_ST = 1'b1
  } timer_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } wait_state_e;

  typedef struct packed {
    timer_sel_e           sel;
    logic [TIMER_W-1:0]   data;
  } timer_wr_t;

endpackage

// File: rtl/chip8_tick_gen.sv
// chip8_tick_gen: DIV-cycle timebase producing the registered 60 Hz tick.
// Optional macro CHIP8_TIMER_PAUSE_EN adds a pause input that freezes the
// counter and suppresses tick.
// Ports:
//   clk_in  - system clock
//   reset   - asynchronous active-low reset
//   pause   - (macro only) hold counter, suppress tick
//   tick    - registered one-cycle pulse, high the cycle after count = DIV-1
//   wrap_c  - combinational: counter is at DIV-1 and advancing this cycle
module chip8_tick_gen #(
  parameter int unsigned DIV = 10,
  parameter int unsigned CW  = $clog2(DIV)
) (
  input  logic clk_in,
  input  logic reset,
`ifdef CHIP8_TIMER_PAUSE_EN
  input  logic pause,
`endif
  output logic tick,
  output logic wrap_c
);

  // DIV must be at least 2 so the terminal count is distinct from reset value.
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          run_c;

`ifdef CHIP8_TIMER_PAUSE_EN
  assign run_c = !pause;
`else
  assign run_c = 1'b1;
`endif

  // Terminal count only counts as a wrap when the counter actually advances.
  assign wrap_c = run_c && (cnt == LAST);

  // Free-running (or paused) modulo-DIV counter and registered tick.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (run_c) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
      tick <= wrap_c;
    end
  end

endmodule

// File: rtl/chip8_timer_ctrl.sv
// chip8_timer_ctrl: CHIP-8 60 Hz timebase, delay/sound timers and
// wait-for-tick handshake. Optional macro CHIP8_TIMER_PAUSE_EN adds a
// pause input that freezes the timebase and the timers (writes still land).
// Ports:
//   clk_in    - system clock
//   reset     - asynchronous active-low reset
//   wr_en     - CPU timer write strobe (single cycle)
//   wr_sel    - 0 = DT, 1 = ST
//   wr_data   - value to load
//   dt_value  - current delay timer
//   sound_on  - high while ST != 0
//   tick      - one-cycle pulse per tick period
//   wait_req  - CPU requests a stall until the next tick
//   pause     - (macro only) freeze timebase and timers
//   wait_done - one-cycle acknowledge of wait_req
module chip8_timer_ctrl
  import chip8_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 60
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [TIMER_W-1:0] wr_data,
  output logic [TIMER_W-1:0] dt_value,
  output logic               sound_on,
  output logic               tick,
  input  logic               wait_req,
`ifdef CHIP8_TIMER_PAUSE_EN
  input  logic               pause,
`endif
  output logic               wait_done
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [TIMER_W-1:0] st_q;
  logic [TIMER_W-1:0] dt_next;
  logic [TIMER_W-1:0] st_next;
  logic               wrap_c;
  timer_wr_t          wr_c;

  assign wr_c = '{sel: timer_sel_e'(wr_sel), data: wr_data};

  // Timebase.
  chip8_tick_gen #(
    .DIV (DIV),
    .CW  (CW)
  ) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
`ifdef CHIP8_TIMER_PAUSE_EN
    .pause  (pause),
`endif
    .tick   (tick),
    .wrap_c (wrap_c)
  );

  // Next-state: saturating decrements, then CPU write overrides its target.
  always_comb begin
    state_next = state;
    dt_next    = dt_value;
    st_next    = st_q;

    if (wrap_c && (dt_value != '0)) dt_next = dt_value - TIMER_W'(1);
    if (wrap_c && (st_q != '0))     st_next = st_q - TIMER_W'(1);

    if (wr_en) begin
      if (wr_c.sel == TMR_DT) dt_next = wr_c.data;
      else                    st_next = wr_c.data;
    end

    // WAIT looks at the registered tick, so a request sampled alongside a
    // tick is only released by the following one.
    case (state)
      S_IDLE:  if (wait_req) state_next = S_WAIT;
      S_WAIT:  if (tick)     state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      dt_value  <= '0;
      st_q      <= '0;
      sound_on  <= 1'b0;
      wait_done <= 1'b0;
    end else begin
      state     <= state_next;
      dt_value  <= dt_next;
      st_q      <= st_next;
      sound_on  <= (st_next != '0);
      wait_done <= (state_next == S_DONE);
    end
  end

endmodule

// File: doc/chip8_timer_ctrl.md
Name: chip8_timer_ctrl

Overview:
Owns the CHIP-8 60 Hz timebase and sequences the two architectural timers: delay timer (DT) and sound timer (ST). Generates the 60 Hz tick internally and decrements each non-zero timer once per tick. Arbitrates CPU writes against tick decrements, and provides a wait-for-tick handshake the CPU uses for frame sync. Sits between the CPU core (FX07/FX15/FX18 execution) and the audio and display blocks.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 60, timer decrement rate in Hz
DIV, CLK_HZ/TICK_HZ (integer, truncated), clock cycles per tick period; minimum legal value 2
CW, $clog2(DIV), tick counter width

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
wr_en  input  1  CPU timer write strobe, single cycle
wr_sel  input  1  0 = write DT, 1 = write ST
wr_data  input  8  value to load
dt_value  output  8  current DT, for FX07
sound_on  output  1  high while ST != 0
tick  output  1  one-cycle pulse each tick period
wait_req  input  1  CPU asks to stall until the next tick
wait_done  output  1  one-cycle acknowledge of wait_req

Behaviour:
- Reset (reset low, asynchronous): tick counter = 0, DT = 0, ST = 0, tick = 0, wait_done = 0, FSM = IDLE. All outputs are low or zero while reset is low.
- Tick counter: counts 0..DIV-1 and wraps to 0. tick is registered and is high for exactly the cycle after the counter reaches DIV-1. Tick period is exactly DIV cycles. First tick after reset release: cycle DIV, counting the first cycle out of reset as cycle 1.
- Decrement: in the cycle where the counter equals DIV-1, each timer that is non-zero decrements by 1 and becomes visible with tick. Timers saturate at 0 and never wrap to 0xFF.
- Write: wr_en loads wr_data into the selected timer on the next edge. Write has 1-cycle latency to dt_value/sound_on.
- Write vs decrement in the same cycle: the write wins on the targeted timer, with no decrement applied to it. The other timer still decrements.
- sound_on: registered, equal to (ST != 0) after each update. Writing ST = 0 drops sound_on on the next cycle.
- Wait FSM:
  - IDLE: if wait_req is high, go to WAIT.
  - WAIT: on the cycle tick is asserted, go to DONE.
  - DONE: wait_done = 1 for one cycle, then go to IDLE. Re-arm requires wait_req to be sampled high again in IDLE.
  - wait_req may drop while in WAIT; the FSM still completes to DONE. The CPU is expected to hold it.
  - A wait_req arriving in the same cycle tick is high is not satisfied by that tick; it waits for the next one.
- Reset mid-wait: FSM returns to IDLE and no wait_done is produced.

Optional Feature:
Macro CHIP8_TIMER_PAUSE_EN.
- Defined: adds port pause (input, 1). While pause is high:
  - The tick counter holds its value.
  - tick stays low.
  - Timers freeze, but CPU writes still apply.
  - The WAIT state holds.
  - Releasing pause resumes counting from the held value.
- Undefined: no pause port. The counter free-runs at all times.

Decomposition:
- Package chip8_pkg holds: the timer_sel_e typedef (TMR_DT = 0, TMR_ST = 1), the wait_state_e typedef (IDLE, WAIT, DONE), and the constant TIMER_W = 8.
- One sub-module, chip8_tick_gen, holds the parameterised DIV counter and the registered tick output (plus the pause input when the macro is defined). The timer registers and wait FSM stay in the top module.

Test Plan:
All scenarios use CLK_HZ = 600, TICK_HZ = 60, so DIV = 10.
1. Release reset and run 35 cycles -> tick pulses at cycles 10, 20 and 30, each exactly 1 cycle wide; all outputs 0 before the first tick.
2. Write DT = 3 -> dt_value reads 3 the next cycle, then 2, 1, 0 on successive ticks, and stays 0 for two further ticks (no wrap to 0xFF).
3. Write ST = 2 -> sound_on rises 1 cycle after the write and falls on the second tick. Separately, write ST = 5 then ST = 0 -> sound_on falls 1 cycle after the second write.
4. DT = 5, ST = 5; on a counter = 9 cycle, write DT = 7 -> next cycle dt_value = 7 and ST = 4.
5. Pulse wait_req 3 cycles after a tick -> wait_done is a single pulse on the cycle after the next tick. Assert wait_req on a tick cycle -> wait_done follows the subsequent tick instead. Assert reset during WAIT -> no wait_done.
6. With CHIP8_TIMER_PAUSE_EN defined and DT = 4: hold pause for 25 cycles -> no tick and dt_value stays 4; after release, the next tick arrives (10 - held count) cycles later.
